issue_select: RTL and testbench
===============================

ISSUE_SELECT -- requirements
Module: issue_select

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of RS entries arbitrated (power of two, 2..32).
REQ-002 SHALL have port clock  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port rs_busy  input  RS_SIZE  per-entry busy from RS_entry.
REQ-005 SHALL have port rs_ready  input  RS_SIZE  per-entry ready (both operands valid) from RS_entry.
REQ-006 SHALL have port rs_packets  input  RS_SIZE x IS_PACKET  per-entry entry_packet from RS_entry.
REQ-007 SHALL have port squash  input  1  branch-mispredict flush.
REQ-008 SHALL have port ex_ready  input  1  execute stage accepts is_packet_out this cycle.
REQ-009 SHALL have port rs_clear  output  RS_SIZE  one-hot (or zero) clear to the granted RS_entry.
REQ-010 SHALL have port is_packet_out  output  IS_PACKET  registered issued packet.
REQ-011 SHALL have port is_valid  output  1  is_packet_out holds a valid instruction.
REQ-012 SHALL have port issue_cnt  output  32  count of instructions issued since reset.

Function
REQ-013 Candidate vector SHALL be rs_busy & rs_ready; an entry with busy=0 SHALL never be granted.
REQ-014 Issue register SHALL load when (!is_valid || ex_ready) && !squash && any candidate; called "grant".
REQ-015 On grant, rs_clear SHALL be combinationally one-hot at granted index in the same cycle; otherwise all zero.
REQ-016 On grant, is_packet_out SHALL take rs_packets[granted index] at the next rising edge and is_valid SHALL be 1 (latency one cycle ready-to-valid).
REQ-017 When is_valid && !ex_ready, is_packet_out and is_valid SHALL hold unchanged and no grant SHALL occur (stall).
REQ-018 When is_valid && ex_ready and no candidate, is_valid SHALL clear at next edge.
REQ-019 When is_valid && ex_ready and a candidate exists, back-to-back issue SHALL occur (one instruction per cycle throughput).
REQ-020 squash SHALL force is_valid to 0 at next edge, suppress grant and rs_clear that cycle, and take priority over ex_ready and candidates.
REQ-021 issue_cnt SHALL increment by 1 per grant, wrapping 0xFFFFFFFF to 0; unchanged on squash-suppressed cycles.
REQ-022 Grant selection SHALL follow the Configuration section; arbiter pointer updates only on grant.

Reset
REQ-023 On reset: is_valid=0, is_packet_out=all zeros, issue_cnt=0, arbiter pointer=0.
REQ-024 During reset, rs_clear SHALL be zero and no grant SHALL occur; reset SHALL override squash and in-flight stalls.

Configuration
REQ-025 Macro ISSUE_RR_ARB_EN defined: round-robin; search starts at pointer, wraps RS_SIZE-1 to 0; after grant at i pointer=(i+1) mod RS_SIZE.
REQ-026 Macro ISSUE_RR_ARB_EN undefined: fixed priority, lowest candidate index wins; pointer logic absent.

Structure
REQ-027 IS_PACKET and RS_SIZE default SHALL come from the shared sys_defs package; no new typedefs local to the module.
REQ-028 Arbitration SHALL be one sub-module rr_arbiter (inputs req, pointer enable; outputs one-hot gnt, gnt index), instantiated once.

Verification
REQ-029 Reset then rs_busy=rs_ready=8'b0000_0100, ex_ready=1 -> rs_clear=8'b0000_0100 same cycle; next cycle is_valid=1, packet=rs_packets[2], issue_cnt=1.
REQ-030 is_valid=1, ex_ready=0 for 3 cycles, candidates 8'hFF -> rs_clear=0 and is_packet_out stable all 3 cycles; ex_ready=1 -> grant resumes.
REQ-031 ISSUE_RR_ARB_EN, candidates 8'hFF held, ex_ready=1 -> grants indices 0,1,...,7,0 on successive cycles; without macro -> index 0 every cycle.
REQ-032 Candidates 8'b1000_0001, pointer=7 (RR) -> grant 7 then wraps to grant 0.
REQ-033 squash=1 with is_valid=1 and candidates 8'h0F -> rs_clear=0 that cycle, is_valid=0 next cycle, issue_cnt unchanged.
REQ-034 rs_busy=0, rs_ready=8'hFF -> no grant, is_valid stays 0; reset asserted mid-stall -> is_valid=0, issue_cnt=0 next cycle.

Source files
------------

// File: rtl/sys_defs.sv
// Shared system definitions: issue packet layout and the default reservation
// station depth used by the issue stage and its arbiter.
package sys_defs;

    // Default number of reservation station entries arbitrated by issue.
    localparam int RS_SIZE_DEFAULT = 8;

    // Packet handed from a reservation station entry to the execute stage.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  dest_tag;
    } IS_PACKET;

endpackage

// File: rtl/issue_select_rr_arbiter.sv
// rr_arbiter: picks one requester out of N for the issue stage.
// Build option ISSUE_RR_ARB_EN selects round-robin (search starts at an
// internal pointer that moves past each granted index). Without it the
// arbiter is fixed priority, lowest index wins, and holds no state.
module rr_arbiter
    import sys_defs::*;
#(
    parameter int N = RS_SIZE_DEFAULT
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int IDX_W = $clog2(N);
    localparam logic [N-1:0]     ONE_HOT_BASE = N'(1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

    logic [IDX_W-1:0] gnt_idx_s;
    logic             found_s;

`ifdef ISSUE_RR_ARB_EN
    logic [IDX_W-1:0] ptr_r;

    // First requester at or after the pointer; index arithmetic wraps because N is a power of two.
    always_comb begin
        logic [IDX_W-1:0] idx_v;
        gnt_idx_s = '0;
        found_s   = 1'b0;
        idx_v     = '0;
        for (int k = 0; k < N; k++) begin
            idx_v = ptr_r + k[IDX_W-1:0];
            if (!found_s && req[idx_v]) begin
                gnt_idx_s = idx_v;
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Pointer moves just past the winner, and only when the grant is actually taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (en && found_s) begin
            ptr_r <= gnt_idx_s + IDX_ONE;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = &{1'b0, clock, reset, en};

    // Lowest-index requester wins.
    always_comb begin
        gnt_idx_s = '0;
        found_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && req[k]) begin
                gnt_idx_s = k[IDX_W-1:0];
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
    end
`endif

    // Expand the winning index to a one-hot grant; all zero when nobody requests.
    always_comb begin
        if (found_s) begin
            gnt = ONE_HOT_BASE << gnt_idx_s;
        end else begin
            gnt = '0;
        end
    end

    assign gnt_idx   = gnt_idx_s;
    assign gnt_valid = found_s;

endmodule

// File: rtl/issue_select.sv
// issue_select: chooses one ready reservation station entry per cycle and
// moves its packet into a single issue register facing the execute stage.
// The entry is told to clear itself in the same cycle it is granted; the
// packet appears on is_packet_out one edge later.
// Optional build macro ISSUE_RR_ARB_EN turns on round-robin arbitration;
// by default the lowest ready index is chosen.
module issue_select
    import sys_defs::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RS_SIZE-1:0]   rs_busy,
    input  logic [RS_SIZE-1:0]   rs_ready,
    input  IS_PACKET [RS_SIZE-1:0] rs_packets,
    input  logic                 squash,
    input  logic                 ex_ready,
    output logic [RS_SIZE-1:0]   rs_clear,
    output IS_PACKET             is_packet_out,
    output logic                 is_valid,
    output logic [31:0]          issue_cnt
);

    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] cand_s;
    logic [RS_SIZE-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic               arb_valid_s;
    logic               grant_s;

    IS_PACKET           is_packet_r;
    logic               is_valid_r;
    logic [31:0]        issue_cnt_r;

    // An entry competes only when it holds an instruction and both operands are present.
    assign cand_s = rs_busy & rs_ready;

    rr_arbiter #(
        .N (RS_SIZE)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (cand_s),
        .en        (grant_s),
        .gnt       (arb_gnt_s),
        .gnt_idx   (arb_idx_s),
        .gnt_valid (arb_valid_s)
    );

    // Grant when the issue slot is free or draining, nothing is being flushed, and reset is low.
    always_comb begin
        if (!reset && !squash && (!is_valid_r || ex_ready) && arb_valid_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Clear pulse to the granted entry, same cycle as the grant.
    always_comb begin
        if (grant_s) begin
            rs_clear = arb_gnt_s;
        end else begin
            rs_clear = '0;
        end
    end

    // Issue register: reset, flush, load, drain or hold, in that priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_packet_r <= '0;
            is_valid_r  <= 1'b0;
            issue_cnt_r <= 32'd0;
        end else if (squash) begin
            is_packet_r <= is_packet_r;
            is_valid_r  <= 1'b0;
            issue_cnt_r <= issue_cnt_r;
        end else if (grant_s) begin
            is_packet_r <= rs_packets[arb_idx_s];
            is_valid_r  <= 1'b1;
            issue_cnt_r <= issue_cnt_r + 32'd1;
        end else if (ex_ready) begin
            is_packet_r <= is_packet_r;
            is_valid_r  <= 1'b0;
            issue_cnt_r <= issue_cnt_r;
        end else begin
            is_packet_r <= is_packet_r;
            is_valid_r  <= is_valid_r;
            issue_cnt_r <= issue_cnt_r;
        end
    end

    assign is_packet_out = is_packet_r;
    assign is_valid      = is_valid_r;
    assign issue_cnt     = issue_cnt_r;

endmodule

// File: tb/tb_issue_select.sv
// Bench for issue_select: directed scenarios with hand-computed pins, then a
// pseudo-random phase, all checked every cycle against a behavioural model.
module tb_issue_select;
    import sys_defs::*;

`ifdef ISSUE_RR_ARB_EN
    localparam bit          RR           = 1'b1;
    localparam logic [7:0]  EXP_RESUME   = 8'h08;
    localparam int          EXP_LAST_IDX = 4;
    localparam logic [7:0]  EXP_WRAP_1ST = 8'h80;
`else
    localparam bit          RR           = 1'b0;
    localparam logic [7:0]  EXP_RESUME   = 8'h01;
    localparam int          EXP_LAST_IDX = 0;
    localparam logic [7:0]  EXP_WRAP_1ST = 8'h01;
`endif

    logic           clock;
    logic           reset;
    logic [7:0]     rs_busy;
    logic [7:0]     rs_ready;
    IS_PACKET [7:0] rs_packets;
    logic           squash;
    logic           ex_ready;
    logic [7:0]     rs_clear;
    IS_PACKET       is_packet_out;
    logic           is_valid;
    logic [31:0]    issue_cnt;

    int n_checks;
    int n_pass;

    // model state: what the registered outputs must hold after the last edge
    bit          m_valid;
    IS_PACKET    m_pkt;
    logic [31:0] m_cnt;
    int          m_ptr;

    issue_select #(.RS_SIZE(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .rs_busy       (rs_busy),
        .rs_ready      (rs_ready),
        .rs_packets    (rs_packets),
        .squash        (squash),
        .ex_ready      (ex_ready),
        .rs_clear      (rs_clear),
        .is_packet_out (is_packet_out),
        .is_valid      (is_valid),
        .issue_cnt     (issue_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Winner by the selection rule: round-robin takes the first candidate at or
    // above the pointer, else the lowest candidate; fixed priority takes the lowest.
    function automatic int pick(input logic [7:0] cand, input int ptr);
        int first_any;
        int first_at;
        first_any = -1;
        first_at  = -1;
        for (int i = 0; i < 8; i++) begin
            if (cand[i]) begin
                if (first_any < 0) first_any = i;
                if (i >= ptr && first_at < 0) first_at = i;
            end
        end
        return (RR && first_at >= 0) ? first_at : first_any;
    endfunction

    // Compare every cycle mid-period, then advance the model across the coming edge.
    always @(negedge clock) begin
        logic [7:0] cand;
        bit         g;
        int         idx;
        logic [7:0] exp_clr;
        cand    = rs_busy & rs_ready;
        g       = !reset && !squash && (!m_valid || ex_ready) && (cand != 8'h00);
        idx     = pick(cand, m_ptr);
        exp_clr = g ? (8'h01 << idx) : 8'h00;
        check("rs_clear", 128'(rs_clear), 128'(exp_clr));
        check("is_valid", 128'(is_valid), 128'(m_valid));
        check("issue_cnt", 128'(issue_cnt), 128'(m_cnt));
        check("is_packet_out", 128'(is_packet_out), 128'(m_pkt));
        if (reset) begin
            m_valid = 1'b0; m_pkt = '0; m_cnt = 32'd0; m_ptr = 0;
        end else if (squash) begin
            m_valid = 1'b0;
        end else if (g) begin
            m_valid = 1'b1; m_pkt = rs_packets[idx]; m_cnt = m_cnt + 32'd1; m_ptr = (idx + 1) % 8;
        end else if (ex_ready) begin
            m_valid = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cand(input logic [7:0] b, input logic [7:0] r);
        rs_busy  = b;
        rs_ready = r;
    endtask

    initial begin
        IS_PACKET p2;
        IS_PACKET plast;
        n_checks = 0; n_pass = 0;
        m_valid = 1'b0; m_pkt = '0; m_cnt = 32'd0; m_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            rs_packets[i].pc       = 32'h1000 + 32'(i * 4);
            rs_packets[i].inst     = 32'hA500_0000 + 32'(i * 32'h111);
            rs_packets[i].dest_tag = 6'(i + 8);
        end
        reset = 1'b1; squash = 1'b0; ex_ready = 1'b0; set_cand(8'h00, 8'h00);
        cyc(); cyc();
        check("reset valid", 128'(is_valid), 128'(1'b0));
        check("reset cnt", 128'(issue_cnt), 128'(32'd0));

        // single ready entry at index 2
        reset = 1'b0; ex_ready = 1'b1; set_cand(8'b0000_0100, 8'b0000_0100);
        #2 check("first clr", 128'(rs_clear), 128'(8'b0000_0100));
        p2 = rs_packets[2];
        cyc();
        check("first valid", 128'(is_valid), 128'(1'b1));
        check("first pkt", 128'(is_packet_out), 128'(p2));
        check("first cnt", 128'(issue_cnt), 128'(32'd1));

        // stall three cycles with everything ready
        ex_ready = 1'b0; set_cand(8'hFF, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            #2 check("stall clr", 128'(rs_clear), 128'(8'h00));
            cyc();
            check("stall pkt", 128'(is_packet_out), 128'(p2));
        end
        ex_ready = 1'b1;
        #2 check("resume clr", 128'(rs_clear), 128'(EXP_RESUME));
        cyc();
        check("resume cnt", 128'(issue_cnt), 128'(32'd2));

        // back-to-back issue, nine cycles
        for (int i = 0; i < 9; i++) cyc();
        plast = rs_packets[EXP_LAST_IDX];
        check("b2b cnt", 128'(issue_cnt), 128'(32'd11));
        check("b2b last pkt", 128'(is_packet_out), 128'(plast));

        // squash with valid slot and candidates
        squash = 1'b1; set_cand(8'h0F, 8'h0F);
        #2 check("squash clr", 128'(rs_clear), 128'(8'h00));
        cyc();
        check("squash valid", 128'(is_valid), 128'(1'b0));
        check("squash cnt", 128'(issue_cnt), 128'(32'd11));
        squash = 1'b0;

        // candidates at both ends
        set_cand(8'b1000_0001, 8'b1000_0001);
        #2 check("wrap clr 1", 128'(rs_clear), 128'(EXP_WRAP_1ST));
        cyc();
        #2 check("wrap clr 2", 128'(rs_clear), 128'(8'h01));
        cyc();
        check("wrap cnt", 128'(issue_cnt), 128'(32'd13));

        // drain: no candidates, slot empties
        set_cand(8'h00, 8'h00);
        cyc();
        check("drain valid", 128'(is_valid), 128'(1'b0));

        // ready but not busy never wins
        set_cand(8'h00, 8'hFF);
        #2 check("notbusy clr", 128'(rs_clear), 128'(8'h00));
        cyc();
        check("notbusy valid", 128'(is_valid), 128'(1'b0));

        // reset in the middle of a stall, with squash also high
        set_cand(8'h01, 8'h01);
        cyc();
        ex_ready = 1'b0; set_cand(8'hFF, 8'hFF);
        cyc();
        reset = 1'b1; squash = 1'b1;
        #2 check("reset clr", 128'(rs_clear), 128'(8'h00));
        cyc();
        check("midreset valid", 128'(is_valid), 128'(1'b0));
        check("midreset cnt", 128'(issue_cnt), 128'(32'd0));
        reset = 1'b0; squash = 1'b0;

        // pseudo-random traffic checked by the model
        for (int i = 0; i < 120; i++) begin
            rs_busy  = 8'($urandom);
            rs_ready = 8'($urandom);
            ex_ready = ($urandom_range(3) != 0);
            squash   = ($urandom_range(9) == 0);
            reset    = ($urandom_range(39) == 0);
            if ($urandom_range(3) == 0) begin
                rs_packets[$urandom_range(7)].inst = $urandom;
            end
            cyc();
        end
        reset = 1'b0; squash = 1'b0; set_cand(8'h00, 8'h00);
        cyc(); cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
